// File: rtl/risc32_if_fetch.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack instruction memory
// and feeds the IF/ID register, honouring branch (delay-slot) and flush redirects.
module risc32_if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        stallreq_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
);

    typedef enum logic [1:0] {IDLE, FETCH, VALID, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        pend_v_q, pend_v_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] redir_q, redir_d;
    logic [31:0] br_tgt, fl_tgt;
    logic        br_consumed;
    logic        unused_bits;

    assign br_tgt      = {branch_target_i[31:2], 2'b00};
    assign fl_tgt      = {new_pc_i[31:2], 2'b00};
    assign br_consumed = (state_q == VALID) && !stall[0];
    assign unused_bits = ^{stall[5:1], branch_target_i[1:0], new_pc_i[1:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            pend_v_q  <= 1'b0;
            pend_pc_q <= '0;
            redir_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            pend_v_q  <= pend_v_d;
            pend_pc_q <= pend_pc_d;
            redir_q   <= redir_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        pend_v_d    = pend_v_q;
        pend_pc_d   = pend_pc_q;
        redir_d     = redir_q;
        imem_req_o  = 1'b0;
        imem_addr_o = pc_q;
        stallreq_o  = 1'b0;
        pc_o        = '0;
        inst_o      = '0;

        if (branch_flag_i && !br_consumed) begin
            pend_v_d  = 1'b1;
            pend_pc_d = br_tgt;
        end

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                imem_req_o = 1'b1;
                stallreq_o = 1'b1;
                if (imem_ack_i) begin
                    inst_d  = imem_rdata_i;
                    state_d = VALID;
                end
            end
            VALID: begin
                pc_o   = pc_q;
                inst_o = inst_q;
                if (!stall[0]) begin
                    pc_d     = branch_flag_i ? br_tgt : (pend_v_q ? pend_pc_q : pc_q + 32'd4);
                    pend_v_d = 1'b0;
                    state_d  = FETCH;
                end
            end
            DRAIN: begin
                imem_req_o = 1'b1;
                stallreq_o = 1'b1;
                if (imem_ack_i) begin
                    pc_d    = redir_q;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush overrides everything above; an in-flight request must still see its ack.
        if (flush_i) begin
            pend_v_d = 1'b0;
            case (state_q)
                FETCH, DRAIN: begin
                    if (imem_ack_i) begin
                        inst_d  = inst_q;
                        pc_d    = fl_tgt;
                        state_d = FETCH;
                    end else begin
                        pc_d    = pc_q;
                        redir_d = fl_tgt;
                        state_d = DRAIN;
                    end
                end
                default: begin
                    pc_d    = fl_tgt;
                    state_d = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risc32_if_fetch.sv
// Directed bench for risc32_if_fetch with a parameterised-latency memory responder.
module tb_risc32_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        stallreq_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          wait_n;
    int          cnt;
    logic        force_en;
    logic [31:0] force_addr;

    risc32_if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
        .flush_i(flush_i), .new_pc_i(new_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
        .stallreq_o(stallreq_o), .pc_o(pc_o), .inst_o(inst_o)
    );

    always #5 clk = ~clk;

    // Memory: acks after wait_n wait cycles, data = addr ^ A5A5_0000 unless forced.
    assign imem_ack_i   = imem_req_o && (cnt == wait_n);
    assign imem_rdata_i = (force_en && imem_addr_o == force_addr) ? 32'hDEAD_BEEF
                                                                  : imem_addr_o ^ 32'hA5A5_0000;
    always @(posedge clk) begin
        if (!rst || !imem_req_o || imem_ack_i) cnt <= 0;
        else cnt <= cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; stall = '0; branch_flag_i = 1'b0; branch_target_i = '0;
        flush_i = 1'b0; new_pc_i = '0; force_en = 1'b0; force_addr = '0; wait_n = 0;
        step(); step();
        rst = 1'b1;
        step();
    endtask

    task automatic go_valid(input logic [31:0] target);
        logic found;
        found = 1'b0;
        do_reset();
        for (int i = 0; i < 64 && !found; i++) begin
            step();
            if (pc_o === target && inst_o === (target ^ 32'hA5A5_0000)) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL reach_valid: pc %h never presented, last pc_o=%h", target, pc_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = '0; branch_flag_i = 1'b0; branch_target_i = '0;
        flush_i = 1'b0; new_pc_i = '0; force_en = 1'b0; force_addr = '0; wait_n = 0;
        step(); step();
        n_cmp++;
        if ({imem_req_o, stallreq_o, imem_addr_o, pc_o, inst_o} !== {2'b00, 96'h0}) begin
            n_bad++;
            $display("FAIL reset_outputs: req=%b stallreq=%b addr=%h pc=%h inst=%h want all 0",
                     imem_req_o, stallreq_o, imem_addr_o, pc_o, inst_o);
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || stallreq_o !== 1'b1) begin
            n_bad++;
            $display("FAIL first_request: req=%b addr=%h stallreq=%b want 1/0/1",
                     imem_req_o, imem_addr_o, stallreq_o);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp_addr [3];
        exp_addr[0] = 32'h0; exp_addr[1] = 32'h4; exp_addr[2] = 32'h8;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== exp_addr[k] || stallreq_o !== 1'b1 ||
                pc_o !== 32'h0 || inst_o !== 32'h0) begin
                n_bad++;
                $display("FAIL zw_fetch%0d: req=%b addr=%h stallreq=%b pc=%h inst=%h want addr %h",
                         k, imem_req_o, imem_addr_o, stallreq_o, pc_o, inst_o, exp_addr[k]);
            end
            if (k == 2) break;
            step();
            n_cmp++;
            if (pc_o !== exp_addr[k] || inst_o !== (32'hA5A5_0000 | exp_addr[k]) ||
                stallreq_o !== 1'b0 || imem_req_o !== 1'b0) begin
                n_bad++;
                $display("FAIL zw_valid%0d: pc=%h inst=%h stallreq=%b req=%b want pc %h",
                         k, pc_o, inst_o, stallreq_o, imem_req_o, exp_addr[k]);
            end
            step();
        end
    endtask

    task automatic test_wait3();
        go_valid(32'h0);
        wait_n = 3;
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4 || stallreq_o !== 1'b1 ||
                pc_o !== 32'h0 || inst_o !== 32'h0) begin
                n_bad++;
                $display("FAIL wait3_cycle%0d: req=%b addr=%h stallreq=%b pc=%h inst=%h want 1/4/1/0/0",
                         k, imem_req_o, imem_addr_o, stallreq_o, pc_o, inst_o);
            end
        end
        step();
        n_cmp++;
        if (pc_o !== 32'h4 || inst_o !== 32'hA5A5_0004 || stallreq_o !== 1'b0) begin
            n_bad++;
            $display("FAIL wait3_present: pc=%h inst=%h stallreq=%b want 4/a5a50004/0",
                     pc_o, inst_o, stallreq_o);
        end
    endtask

    task automatic test_branch_valid();
        go_valid(32'h8);
        branch_flag_i = 1'b1; branch_target_i = 32'h0000_0100;
        step();
        branch_flag_i = 1'b0;
        n_cmp++;
        if (imem_addr_o !== 32'h100 || imem_req_o !== 1'b1) begin
            n_bad++;
            $display("FAIL branch_now: addr=%h req=%b want 00000100/1", imem_addr_o, imem_req_o);
        end
        go_valid(32'h8);
        stall = 6'b000001;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if (pc_o !== 32'h8 || imem_req_o !== 1'b0 || inst_o !== 32'hA5A5_0008) begin
                n_bad++;
                $display("FAIL stall_hold%0d: pc=%h inst=%h req=%b want 8/a5a50008/0",
                         k, pc_o, inst_o, imem_req_o);
            end
        end
        stall = '0;
        step();
        n_cmp++;
        if (imem_addr_o !== 32'hC || imem_req_o !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_release: addr=%h req=%b want 0000000c/1", imem_addr_o, imem_req_o);
        end
    endtask

    task automatic test_delay_slot();
        go_valid(32'h8);
        wait_n = 2;
        step();
        branch_flag_i = 1'b1; branch_target_i = 32'h0000_0203;
        step();
        branch_flag_i = 1'b0;
        step(); step();
        n_cmp++;
        if (pc_o !== 32'hC || inst_o !== 32'hA5A5_000C) begin
            n_bad++;
            $display("FAIL delay_slot: pc=%h inst=%h want 0000000c/a5a5000c", pc_o, inst_o);
        end
        step();
        n_cmp++;
        if (imem_addr_o !== 32'h200 || imem_req_o !== 1'b1) begin
            n_bad++;
            $display("FAIL branch_pending: addr=%h req=%b want 00000200/1", imem_addr_o, imem_req_o);
        end
    endtask

    task automatic test_flush();
        logic seen_bad;
        seen_bad = 1'b0;
        go_valid(32'hC);
        wait_n = 2; force_en = 1'b1; force_addr = 32'h10;
        step();
        flush_i = 1'b1; new_pc_i = 32'h0000_0080;
        step();
        flush_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10 || stallreq_o !== 1'b1 ||
                inst_o !== 32'h0) begin
                n_bad++;
                $display("FAIL drain_hold%0d: req=%b addr=%h stallreq=%b inst=%h want 1/10/1/0",
                         k, imem_req_o, imem_addr_o, stallreq_o, inst_o);
            end
            if (k == 0) step();
        end
        step();
        n_cmp++;
        if (imem_addr_o !== 32'h80 || imem_req_o !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_target: addr=%h req=%b want 00000080/1", imem_addr_o, imem_req_o);
        end
        for (int k = 0; k < 3; k++) begin
            if (inst_o === 32'hDEAD_BEEF) seen_bad = 1'b1;
            step();
        end
        n_cmp++;
        if (seen_bad || pc_o !== 32'h80 || inst_o !== 32'hA5A5_0080) begin
            n_bad++;
            $display("FAIL flush_present: pc=%h inst=%h deadbeef_seen=%b want 80/a5a50080/0",
                     pc_o, inst_o, seen_bad);
        end
    endtask

    task automatic test_flush_wrap();
        go_valid(32'h0);
        flush_i = 1'b1; new_pc_i = 32'hFFFF_FFFF;
        step();
        flush_i = 1'b0;
        n_cmp++;
        if (imem_addr_o !== 32'hFFFF_FFFC || imem_req_o !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_valid: addr=%h req=%b want fffffffc/1", imem_addr_o, imem_req_o);
        end
        step();
        n_cmp++;
        if (pc_o !== 32'hFFFF_FFFC || inst_o !== 32'h5A5A_FFFC) begin
            n_bad++;
            $display("FAIL wrap_present: pc=%h inst=%h want fffffffc/5a5afffc", pc_o, inst_o);
        end
        step();
        n_cmp++;
        if (imem_addr_o !== 32'h0 || imem_req_o !== 1'b1) begin
            n_bad++;
            $display("FAIL pc_wrap: addr=%h req=%b want 00000000/1", imem_addr_o, imem_req_o);
        end
    endtask

    task automatic test_reset_mid_fetch();
        go_valid(32'h4);
        wait_n = 5;
        step();
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin
            n_bad++;
            $display("FAIL midrst_pre: req=%b addr=%h want 1/00000008", imem_req_o, imem_addr_o);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if ({imem_req_o, stallreq_o, imem_addr_o, pc_o, inst_o} !== {2'b00, 96'h0}) begin
            n_bad++;
            $display("FAIL midrst_outputs: req=%b stallreq=%b addr=%h pc=%h inst=%h want all 0",
                     imem_req_o, stallreq_o, imem_addr_o, pc_o, inst_o);
        end
        rst = 1'b1; wait_n = 0;
        step();
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            n_bad++;
            $display("FAIL midrst_restart: req=%b addr=%h want 1/00000000", imem_req_o, imem_addr_o);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait3();
        test_branch_valid();
        test_delay_slot();
        test_flush();
        test_flush_wrap();
        test_reset_mid_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
